uart_cmd_framer: RTL
====================

// Module: uart_cmd_framer
// PURPOSE
//  Sequences the byte stream from uart_rx (data_o/valid_o) into framed register-write
//  packets: SYNC, ADDR, LEN, LEN payload bytes, optional CHK. Buffers payload, commits
//  only intact packets, then drains them as auto-incrementing writes on a valid/ready bus.
//  Sits between uart_rx and the host-facing register file.
// PARAMETERS
//  MAX_LEN         16      max payload bytes per packet (buffer depth), 1..255
//  TIMEOUT_CLOCKS  1200    inter-byte timeout in clocks while mid-packet (>=2)
//  SYNC_BYTE       8'hA5   packet start marker
// PORTS
//  clock           in   1  single clock domain
//  reset           in   1  asynchronous, active-high
//  rx_data_i       in   8  byte from uart_rx data_o
//  rx_valid_i      in   1  1-cycle strobe from uart_rx valid_o; no backpressure
//  wr_addr_o       out  8  write address
//  wr_data_o       out  8  write data
//  wr_valid_o      out  1  write request; held with addr/data stable until wr_ready_i
//  wr_ready_i      in   1  write accepted when wr_valid_o & wr_ready_i
//  pkt_done_o      out  1  1-cycle pulse after last write of a packet is accepted
//  busy_o          out  1  high in any state other than HUNT
//  err_length_o    out  1  1-cycle pulse: LEN > MAX_LEN
//  err_timeout_o   out  1  1-cycle pulse: inter-byte timeout mid-packet
//  err_overflow_o  out  1  1-cycle pulse: byte arrived during DRAIN (byte dropped)
//  err_checksum_o  out  1  1-cycle pulse: CHK mismatch (only with CMD_CHECKSUM_EN)
// BEHAVIOUR
//  - Reset: state=HUNT; all outputs 0; buffer pointers, counters, checksum cleared.
//  - States: HUNT, ADDR, LEN, PAYLOAD, CHK, DRAIN. Transitions on rx_valid_i only, except
//    DRAIN and timeouts.
//  - HUNT: byte==SYNC_BYTE -> ADDR; other bytes ignored silently.
//  - ADDR: latch base address -> LEN. csum <= byte.
//  - LEN: LEN>MAX_LEN -> err_length pulse, HUNT. LEN==0 -> CHK (or commit, see config).
//    else latch count -> PAYLOAD. csum ^= byte.
//  - PAYLOAD: write byte to buffer[idx], idx++, csum ^= byte; after LEN-th byte -> CHK.
//  - CHK: byte==csum -> commit; else err_checksum pulse, HUNT, buffer discarded.
//  - Commit: LEN>0 -> DRAIN with rd idx 0. LEN==0 -> pkt_done pulse, HUNT (no writes).
//  - DRAIN: wr_valid_o=1, wr_addr_o=base+rd (8-bit wrap: 0xFF+1 -> 0x00),
//    wr_data_o=buffer[rd]. On accept rd++. After last accept, wr_valid_o deasserts the next
//    cycle, pkt_done pulses that cycle, state -> HUNT. Back-to-back accepts: 1 write/clock.
//  - Latency: first wr_valid_o asserted the cycle after the commit-triggering rx_valid_i.
//  - rx_valid_i in DRAIN: err_overflow pulse, byte dropped (even if SYNC), drain continues.
//  - Timeout: counter reloads on every accepted byte in ADDR..CHK; reaching TIMEOUT_CLOCKS
//    with no byte -> err_timeout pulse, HUNT. Counter idle in HUNT and DRAIN (DRAIN waits on
//    wr_ready_i indefinitely).
//  - Timeout expiry and rx_valid_i in the same cycle: byte wins, counter reloads.
//  - Async reset mid-DRAIN: wr_valid_o drops immediately; the partial packet is lost.
//  - Error outputs are mutually exclusive per cycle; at most one pulse per packet.
// CONFIGURATION
//  CMD_CHECKSUM_EN defined: CHK state present, as above.
//  CMD_CHECKSUM_EN undefined: no CHK byte; commit on last payload byte (LEN==0 commits in
//    LEN state); err_checksum_o tied 0; csum logic removed.
// TESTING
//  1 A5 10 02 11 22 (CHK 21) -> writes (10,11),(11,22) then pkt_done; no errors.
//  2 Same packet, CHK=00 -> err_checksum pulse, no wr_valid_o, busy_o low after.
//  3 A5 00 11 (MAX_LEN=16) -> err_length pulse at LEN byte; a following valid packet works.
//  4 A5 40 03 01, stall > TIMEOUT_CLOCKS -> err_timeout pulse; then a full packet is accepted.
//  5 A5 FF 02 AA BB +CHK, wr_ready_i low 5 clocks -> addr/data held; addrs FF then 00.
//  6 Byte arrives during DRAIN -> err_overflow pulse, all buffered writes still complete;
//    reset asserted mid-DRAIN -> wr_valid_o=0 same cycle, busy_o=0.

Source files
------------

// File: rtl/uart_cmd_framer_if.sv
// Signal bundle between uart_rx, uart_cmd_framer and the register file.
// master: the framer's view of the bundle; slave: the view from the surrounding blocks.
interface uart_cmd_framer_if;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic [7:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic       wr_valid_o;
  logic       wr_ready_i;
  logic       pkt_done_o;
  logic       busy_o;
  logic       err_length_o;
  logic       err_timeout_o;
  logic       err_overflow_o;
  logic       err_checksum_o;

  modport master (
    input  rx_data_i, rx_valid_i, wr_ready_i,
    output wr_addr_o, wr_data_o, wr_valid_o, pkt_done_o, busy_o,
           err_length_o, err_timeout_o, err_overflow_o, err_checksum_o
  );

  modport slave (
    output rx_data_i, rx_valid_i, wr_ready_i,
    input  wr_addr_o, wr_data_o, wr_valid_o, pkt_done_o, busy_o,
           err_length_o, err_timeout_o, err_overflow_o, err_checksum_o
  );
endinterface

// File: rtl/uart_cmd_framer.sv
// Frames uart_rx bytes (SYNC, ADDR, LEN, payload, optional CHK) into buffered register writes.
// Define CMD_CHECKSUM_EN to require and verify a trailing XOR checksum byte.
module uart_cmd_framer #(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CLOCKS = 1200,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input logic               clock,
  input logic               reset,
  uart_cmd_framer_if.master bus
);

  localparam int unsigned IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned DEPTH    = 1 << IW;
  localparam int unsigned TW       = $clog2(TIMEOUT_CLOCKS);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CLOCKS - 1);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {HUNT, ADDR, LEN, PAYLOAD, CHK, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [7:0]    baseAddr_q, baseAddr_d;
  logic [7:0]    lenByte_q, lenByte_d;
  logic [7:0]    remain_q, remain_d;
  logic [IW-1:0] wrIdx_q, wrIdx_d;
  logic [IW-1:0] rdIdx_q, rdIdx_d;
  logic [TW-1:0] idleCnt_q, idleCnt_d;
  logic          ovfSeen_q, ovfSeen_d;
  logic          pktDone_q, pktDone_d;
  logic          errLength_q, errLength_d;
  logic          errTimeout_q, errTimeout_d;
  logic          errOverflow_q, errOverflow_d;
  logic [7:0]    bufMem_q [DEPTH];
  logic          bufWe;
  logic          midPacket;
  logic [7:0]    rxByte;
  logic          rxValid;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
  logic          errChecksum_q, errChecksum_d;
`endif

  assign rxByte    = bus.rx_data_i;
  assign rxValid   = bus.rx_valid_i;
  assign midPacket = (state_q == ADDR) || (state_q == LEN) ||
                     (state_q == PAYLOAD) || (state_q == CHK);

  always_comb begin
    state_d       = state_q;
    baseAddr_d    = baseAddr_q;
    lenByte_d     = lenByte_q;
    remain_d      = remain_q;
    wrIdx_d       = wrIdx_q;
    rdIdx_d       = rdIdx_q;
    idleCnt_d     = '0;
    ovfSeen_d     = ovfSeen_q;
    pktDone_d     = 1'b0;
    errLength_d   = 1'b0;
    errTimeout_d  = 1'b0;
    errOverflow_d = 1'b0;
    bufWe         = 1'b0;
`ifdef CMD_CHECKSUM_EN
    csum_d        = csum_q;
    errChecksum_d = 1'b0;
`endif

    // A byte arriving on the expiry cycle wins, so the timer only acts on idle cycles.
    if (midPacket && !rxValid) begin
      if (idleCnt_q == TMR_LAST) begin
        errTimeout_d = 1'b1;
        state_d      = HUNT;
      end else begin
        idleCnt_d = idleCnt_q + TW'(1);
      end
    end

    case (state_q)
      HUNT: begin
        if (rxValid && (rxByte == SYNC_BYTE)) state_d = ADDR;
      end
      ADDR: begin
        if (rxValid) begin
          baseAddr_d = rxByte;
          state_d    = LEN;
`ifdef CMD_CHECKSUM_EN
          csum_d     = rxByte;
`endif
        end
      end
      LEN: begin
        if (rxValid) begin
          lenByte_d = rxByte;
          remain_d  = rxByte;
          wrIdx_d   = '0;
`ifdef CMD_CHECKSUM_EN
          csum_d    = csum_q ^ rxByte;
`endif
          if (rxByte > MAX_LEN_B) begin
            errLength_d = 1'b1;
            state_d     = HUNT;
          end else if (rxByte == 8'd0) begin
`ifdef CMD_CHECKSUM_EN
            state_d   = CHK;
`else
            pktDone_d = 1'b1;
            state_d   = HUNT;
`endif
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (rxValid) begin
          bufWe    = 1'b1;
          wrIdx_d  = wrIdx_q + IW'(1);
          remain_d = remain_q - 8'd1;
`ifdef CMD_CHECKSUM_EN
          csum_d   = csum_q ^ rxByte;
          if (remain_q == 8'd1) state_d = CHK;
`else
          if (remain_q == 8'd1) begin
            state_d   = DRAIN;
            remain_d  = lenByte_q;
            rdIdx_d   = '0;
            ovfSeen_d = 1'b0;
          end
`endif
        end
      end
`ifdef CMD_CHECKSUM_EN
      CHK: begin
        if (rxValid) begin
          if (rxByte != csum_q) begin
            errChecksum_d = 1'b1;
            state_d       = HUNT;
          end else if (lenByte_q == 8'd0) begin
            pktDone_d = 1'b1;
            state_d   = HUNT;
          end else begin
            state_d   = DRAIN;
            remain_d  = lenByte_q;
            rdIdx_d   = '0;
            ovfSeen_d = 1'b0;
          end
        end
      end
`endif
      DRAIN: begin
        // Bytes during drain are dropped; only the first one per packet is flagged.
        if (rxValid && !ovfSeen_q) begin
          errOverflow_d = 1'b1;
          ovfSeen_d     = 1'b1;
        end
        if (bus.wr_ready_i) begin
          rdIdx_d  = rdIdx_q + IW'(1);
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) begin
            pktDone_d = 1'b1;
            state_d   = HUNT;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      baseAddr_q    <= '0;
      lenByte_q     <= '0;
      remain_q      <= '0;
      wrIdx_q       <= '0;
      rdIdx_q       <= '0;
      idleCnt_q     <= '0;
      ovfSeen_q     <= 1'b0;
      pktDone_q     <= 1'b0;
      errLength_q   <= 1'b0;
      errTimeout_q  <= 1'b0;
      errOverflow_q <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      csum_q        <= '0;
      errChecksum_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      baseAddr_q    <= baseAddr_d;
      lenByte_q     <= lenByte_d;
      remain_q      <= remain_d;
      wrIdx_q       <= wrIdx_d;
      rdIdx_q       <= rdIdx_d;
      idleCnt_q     <= idleCnt_d;
      ovfSeen_q     <= ovfSeen_d;
      pktDone_q     <= pktDone_d;
      errLength_q   <= errLength_d;
      errTimeout_q  <= errTimeout_d;
      errOverflow_q <= errOverflow_d;
`ifdef CMD_CHECKSUM_EN
      csum_q        <= csum_d;
      errChecksum_q <= errChecksum_d;
`endif
    end
  end

  // Payload storage needs no reset: it is only read after being written by a packet.
  always_ff @(posedge clock) begin
    if (bufWe) bufMem_q[wrIdx_q] <= rxByte;
  end

  assign bus.wr_valid_o     = (state_q == DRAIN);
  assign bus.wr_addr_o      = bus.wr_valid_o ? (baseAddr_q + 8'(rdIdx_q)) : 8'h00;
  assign bus.wr_data_o      = bus.wr_valid_o ? bufMem_q[rdIdx_q] : 8'h00;
  assign bus.busy_o         = (state_q != HUNT);
  assign bus.pkt_done_o     = pktDone_q;
  assign bus.err_length_o   = errLength_q;
  assign bus.err_timeout_o  = errTimeout_q;
  assign bus.err_overflow_o = errOverflow_q;
`ifdef CMD_CHECKSUM_EN
  assign bus.err_checksum_o = errChecksum_q;
`else
  assign bus.err_checksum_o = 1'b0;
`endif

endmodule
